// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes and FSM states.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, legality checks
// and load extraction/extension for one access.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic        misaligned,
    output logic        illegal,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be         = 4'b0000;
        wdata_rep  = 32'h0;
        misaligned = 1'b0;
        illegal    = 1'b0;
        load_data  = 32'h0;
        shifted    = rword >> {offset, 3'b000};

        case (funct3)
            F3_B, F3_BU: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                be         = 4'b0011 << offset;
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = offset[0];
            end
            F3_W: begin
                be         = 4'b1111;
                wdata_rep  = wdata;
                misaligned = (offset != 2'b00);
            end
            default: illegal = 1'b1;
        endcase

        // Unsigned variants exist only for loads.
        if (we && (funct3 == F3_BU || funct3 == F3_HU))
            illegal = 1'b1;

        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data = {24'h0, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data = {16'h0, shifted[15:0]};
            F3_W:    load_data = shifted;
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle memory stage: one load/store per handshake to a word-addressed data port.
// Optional LSU_TIMEOUT_EN aborts an access with an error after TIMEOUT_CYCLES BUSY cycles.
//
// state | meaning
// IDLE  | ready for a request, no access outstanding
// BUSY  | mem_req held, waiting for mem_ack (or timeout)
// RESP  | one-cycle response to writeback
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic [4:0]        rd_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              in_idle;
    logic              accept;
    logic              bad;
    logic              timeout_hit;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic              misaligned;
    logic              illegal;
    logic [31:0]       load_data;

    assign in_idle = (state_q == IDLE);
    assign accept  = in_idle && req_valid;
    assign bad     = illegal | misaligned;

    // While idle the aligner checks the incoming request; afterwards it
    // works on the registered access so load extraction sees the right lane.
    lsu_align u_align (
        .we         (in_idle ? req_we : we_q),
        .funct3     (in_idle ? req_funct3 : f3_q),
        .offset     (in_idle ? req_addr[1:0] : addr_q[1:0]),
        .wdata      (req_wdata),
        .rword      (mem_rdata),
        .be         (be),
        .wdata_rep  (wdata_rep),
        .misaligned (misaligned),
        .illegal    (illegal),
        .load_data  (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (accept)
            cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
        else if (state_q == BUSY && !mem_ack && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign timeout_hit = (state_q == BUSY) && !mem_ack && (cnt_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = bad ? RESP : BUSY;
            BUSY:    if (mem_ack || timeout_hit) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            rd_q    <= 5'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= wdata_rep;
            be_q    <= be;
            rd_q    <= req_rd;
            rdata_q <= 32'h0;
            err_q   <= bad;
        end else if (state_q == BUSY) begin
            if (mem_ack)
                rdata_q <= we_q ? 32'h0 : load_data;
            else if (timeout_hit)
                err_q <= 1'b1;
        end
    end

    assign req_ready  = in_idle;
    assign stall      = !in_idle;
    assign mem_req    = (state_q == BUSY);
    assign mem_we     = mem_req & we_q;
    assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_req ? wdata_q : 32'h0;
    assign mem_be     = mem_req ? be_q : 4'b0000;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign resp_rd    = resp_valid ? rd_q : 5'd0;
    assign resp_err   = resp_valid & err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle memory-stage block between execute and writeback. Takes one load/store per handshake (address = aluout, store data = data2, funct3 size), drives a word-addressed data-memory port with byte enables, waits for memory acknowledge, and returns aligned, sign- or zero-extended load data to writeback. Holds the core via `stall` while a transaction is outstanding, replacing the zero-latency data memory.

Parameters:
TIMEOUT_CYCLES, 16, cycles in BUSY without `mem_ack` before the access aborts with error (LSU_TIMEOUT_EN only).
ADDR_W, 32, byte address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  1  execute presents a load/store (memread|memwrite)
req_ready  out  1  LSU can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  access size/sign
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data (rs2)
req_rd  in  5  load destination register, echoed back
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_rd  out  5  echoed req_rd
resp_err  out  1  misaligned, illegal funct3 or timeout; qualified by resp_valid
stall  out  1  high whenever state != IDLE
mem_req  out  1  memory request, held until ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  memory completion, single cycle
mem_rdata  in  32  read word, valid with mem_ack

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
- FSM states: IDLE, BUSY, RESP.
  - IDLE→BUSY on req_valid&req_ready for a legal, aligned access. All request fields are registered.
  - IDLE→RESP directly with err=1 for illegal or misaligned accesses; no mem_req is issued.
  - BUSY→RESP on mem_ack. mem_rdata is captured in that same cycle.
  - RESP→IDLE unconditionally. resp_valid is high for exactly that one RESP cycle. There is no resp backpressure.
- Legal funct3:
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
  - Any other value is illegal.
- Misalignment: halfword with addr[0]=1; word with addr[1:0]!=0.
- In BUSY: mem_req=1, and mem_we/addr/wdata/be stay stable until the ack cycle inclusive. mem_req drops the cycle after the ack.
- Latency: ack in cycle N → resp_valid in cycle N+1. Minimum total is 3 cycles (accept, ack, resp).
- Byte enables: mem_be = 4'b0001<<addr[1:0] for byte, 4'b0011<<addr[1:0] for half, 4'b1111 for word.
- Store write data: byte replicated to all 4 lanes, half replicated to both halves.
- Load data: extracted at the byte offset. LB/LH are sign-extended from bit 7/15; LBU/LHU are zero-extended.
- mem_ack outside BUSY is ignored, including a late ack after reset or timeout.
- req_valid while not ready is ignored; execute must hold it.
- Reset mid-BUSY: mem_req drops immediately and no response is produced.

Optional Feature:
LSU_TIMEOUT_EN
- Defined: a counter increments each BUSY cycle without ack. On reaching TIMEOUT_CYCLES-1 with no ack, the access aborts: mem_req drops, state goes to RESP with resp_err=1 and resp_rdata=0. The counter clears on entering BUSY.
- Undefined: no counter; BUSY waits indefinitely. resp_err then covers only misaligned or illegal accesses.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5) and the FSM state enum lsu_state_t {IDLE, BUSY, RESP}.
- One combinational sub-module, lsu_align. It computes mem_be, replicated wdata, misaligned/illegal flags and the extended load data from funct3, addr[1:0] and the raw word.

Test Plan:
- Load-word: LW addr 0x10, ack 2 cycles after mem_req with rdata 0x0000_0004 → mem_be=1111, mem_addr=0x10, one resp_valid pulse with rdata=4, stall high for 4 cycles.
- Byte sign handling: LB addr 0x13, rdata 0x80AB_CDEF → resp_rdata=0xFFFF_FF80; LBU at the same address → 0x0000_0080.
- Store byte: SB addr 0x21, wdata 0x1234_56A5 → mem_we=1, mem_be=0010, mem_wdata=0xA5A5_A5A5, resp_rdata=0.
- Misaligned/illegal: LW addr 0x06 → no mem_req, resp_valid+resp_err the cycle after accept. Load with funct3=3 → resp_err=1.
- Timeout (LSU_TIMEOUT_EN): no ack → mem_req drops after 16 BUSY cycles, resp_err=1. A late ack afterwards produces no response.
- Reset mid-BUSY: assert rst 2 cycles into BUSY → mem_req=0 immediately, req_ready=1, no resp_valid. The next LW completes normally.
